// File: rtl/transpose_rd_ctrl.sv
// Column-major read controller for the transpose ping buffer, draining into a valid/ready stream via a 4-entry credit-managed skid FIFO.
// Optional feature: define TRANSPOSE_RD_STALL_CNT_EN to add the perf_stall_cnt output-stall counter.
module transpose_rd_ctrl #(
    parameter int DAT_WIDTH      = 256,
    parameter int MEM_DEPTH      = 16,
    parameter int log2_MEM_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [log2_MEM_DEPTH:0]   cfg_rows,
    input  logic [log2_MEM_DEPTH:0]   cfg_cols,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err,
    output logic                      rd_vld,
    input  logic                      rd_rdy,
    output logic [log2_MEM_DEPTH-1:0] raddr,
    output logic [log2_MEM_DEPTH:0]   raddr_max,
    input  logic [DAT_WIDTH-1:0]      rdata,
    input  logic                      rd_dat_out_vld,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [DAT_WIDTH-1:0]      out_dat,
    output logic                      out_last
`ifdef TRANSPOSE_RD_STALL_CNT_EN
    ,
    output logic [31:0]               perf_stall_cnt
`endif
);

    localparam int AW = log2_MEM_DEPTH;
    localparam int CW = log2_MEM_DEPTH + 1;
    localparam int PW = 2 * CW;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        rows_q, rows_d;
    logic [CW-1:0]        cols_q, cols_d;
    logic [AW-1:0]        raddr_q, raddr_d;
    logic [CW-1:0]        raddr_max_q, raddr_max_d;
    logic [CW-1:0]        row_cnt_q, row_cnt_d;
    logic [CW-1:0]        col_cnt_q, col_cnt_d;
    logic [CW-1:0]        rd_idx_q, rd_idx_d;
    logic [CW-1:0]        push_idx_q, push_idx_d;
    logic [2:0]           inflight_q, inflight_d;
    logic [2:0]           fifo_cnt_q, fifo_cnt_d;
    logic [1:0]           wr_ptr_q, wr_ptr_d;
    logic [1:0]           rd_ptr_q, rd_ptr_d;
    logic                 cfg_err_q, cfg_err_d;
    logic [DAT_WIDTH-1:0] fifo_dat_q [4];
    logic [DAT_WIDTH-1:0] fifo_dat_d [4];
    logic [3:0]           fifo_last_q, fifo_last_d;

    logic [PW-1:0] cfg_prod;
    logic          cfg_legal;
    logic [3:0]    occ_sum;
    logic          credit_ok;
    logic          rd_acc;
    logic          push;
    logic          pop;
    logic          inflight_dec;

    assign cfg_prod  = PW'(cfg_rows) * PW'(cfg_cols);
    assign cfg_legal = (cfg_rows != '0) && (cfg_cols != '0) && (cfg_prod <= PW'(MEM_DEPTH));

    // Credits cover both stored entries and reads whose data is still on its way back.
    assign occ_sum   = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    assign credit_ok = (occ_sum <= 4'd3);

    assign rd_vld       = (state_q == RUN) && credit_ok;
    assign rd_acc       = rd_vld && rd_rdy;
    assign push         = rd_dat_out_vld && (state_q != IDLE);
    assign out_vld      = (fifo_cnt_q != 3'd0);
    assign pop          = out_vld && out_rdy;
    assign inflight_dec = push && (inflight_q != 3'd0);

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DRAIN) && (fifo_cnt_q == 3'd0) && (inflight_q == 3'd0);
    assign cfg_err   = cfg_err_q;
    assign raddr     = raddr_q;
    assign raddr_max = raddr_max_q;
    assign out_dat   = fifo_dat_q[rd_ptr_q];
    assign out_last  = out_vld && fifo_last_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        raddr_d     = raddr_q;
        raddr_max_d = raddr_max_q;
        row_cnt_d   = row_cnt_q;
        col_cnt_d   = col_cnt_q;
        rd_idx_d    = rd_idx_q;
        cfg_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_legal) begin
                        state_d     = RUN;
                        rows_d      = cfg_rows;
                        cols_d      = cfg_cols;
                        raddr_max_d = cfg_prod[CW-1:0];
                        raddr_d     = '0;
                        row_cnt_d   = '0;
                        col_cnt_d   = '0;
                        rd_idx_d    = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (rd_acc) begin
                    rd_idx_d = rd_idx_q + CW'(1);
                    // Column wrap restarts at the top of the next column instead of multiplying.
                    if (row_cnt_q == rows_q - CW'(1)) begin
                        row_cnt_d = '0;
                        col_cnt_d = col_cnt_q + CW'(1);
                        raddr_d   = col_cnt_d[AW-1:0];
                    end else begin
                        row_cnt_d = row_cnt_q + CW'(1);
                        raddr_d   = AW'({1'b0, raddr_q} + cols_q);
                    end
                    if (rd_idx_q == raddr_max_q - CW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inflight_d  = inflight_q;
        fifo_cnt_d  = fifo_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        push_idx_d  = push_idx_q;
        fifo_dat_d  = fifo_dat_q;
        fifo_last_d = fifo_last_q;
        if (rd_acc && !inflight_dec) begin
            inflight_d = inflight_q + 3'd1;
        end else if (!rd_acc && inflight_dec) begin
            inflight_d = inflight_q - 3'd1;
        end
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 3'd1;
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - 3'd1;
        end
        // Data returns in request order, so the push index identifies the tile's final beat.
        if (state_q == IDLE) begin
            push_idx_d = '0;
        end else if (push) begin
            push_idx_d = push_idx_q + CW'(1);
        end
        if (push) begin
            fifo_dat_d[wr_ptr_q]  = rdata;
            fifo_last_d[wr_ptr_q] = (push_idx_q == raddr_max_q - CW'(1));
            wr_ptr_d              = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rows_q      <= '0;
            cols_q      <= '0;
            raddr_q     <= '0;
            raddr_max_q <= '0;
            row_cnt_q   <= '0;
            col_cnt_q   <= '0;
            rd_idx_q    <= '0;
            push_idx_q  <= '0;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cfg_err_q   <= 1'b0;
            fifo_last_q <= '0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            raddr_q     <= raddr_d;
            raddr_max_q <= raddr_max_d;
            row_cnt_q   <= row_cnt_d;
            col_cnt_q   <= col_cnt_d;
            rd_idx_q    <= rd_idx_d;
            push_idx_q  <= push_idx_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cfg_err_q   <= cfg_err_d;
            fifo_last_q <= fifo_last_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_dat_q <= fifo_dat_d;
    end

    always_ff @(posedge clk) begin
        if (!rst && push && !pop) begin
            assert (fifo_cnt_q != 3'd4);
        end
    end

`ifdef TRANSPOSE_RD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start && cfg_legal) begin
            stall_cnt_d = '0;
        end else if (busy && out_vld && !out_rdy && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
